// File: rtl/audio_ram_stream_ctrl.sv
// rtl/audio_ram_stream_ctrl.sv - audio RAM circular-buffer playback sequencer (optional AUDIO_UNDERRUN_CNT_EN)
module audio_ram_stream_ctrl #(
   parameter int ADDR_W    = 14,
   parameter int LOW_WATER = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        csr_address,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   input  logic [7:0]        mem_readdata,
   output logic [15:0]       sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              irq
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR_LO = 3'd1,
      S_CAP_LO  = 3'd2,
      S_CAP_HI  = 3'd3,
      S_VALID   = 3'd4
   } state_t;

   localparam logic [1:0]        A_CTRL   = 2'd0;
   localparam logic [1:0]        A_WR_PTR = 2'd1;
   localparam logic [1:0]        A_RD_PTR = 2'd2;
   localparam logic [1:0]        A_STATUS = 2'd3;
   localparam logic [ADDR_W:0]   LOW_WATER_C = (ADDR_W+1)'(LOW_WATER);
   localparam logic [ADDR_W-1:0] PAIR = ADDR_W'(2);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                enable_q, enable_d;
   logic                irq_en_q, irq_en_d;
   logic                underrun_q, underrun_d;
   logic                urun_cond_q;
   logic [7:0]          lo_q, lo_d;
   logic [15:0]         data_q, data_d;
   logic [31:0]         readdata_q, readdata_d;

   logic [ADDR_W-1:0]   level;
   logic [ADDR_W-1:0]   level_next;
   logic                empty;
   logic                low_water;
   logic                has_pair;
   logic                has_pair_next;
   logic                wr_ctrl, wr_wptr, wr_stat;
   logic                flush;
   logic                urun_clr;
   logic                urun_cond;
   logic                urun_set;
   logic                handshake;
   logic [7:0]          cnt_field;
   logic [31:0]         status;
   logic                unused_wdata;

   // Fill level is derived purely from the registered pointers.
   assign level     = wr_ptr_q - rd_ptr_q;
   assign empty     = (level == '0);
   assign low_water = ({1'b0, level} < LOW_WATER_C);
   assign has_pair  = (level >= PAIR);

   assign wr_ctrl  = csr_write && (csr_address == A_CTRL);
   assign wr_wptr  = csr_write && (csr_address == A_WR_PTR);
   assign wr_stat  = csr_write && (csr_address == A_STATUS);
   assign flush    = wr_ctrl && csr_writedata[2];
   assign urun_clr = wr_stat && csr_writedata[1];

   // Gating with enable means an aborting VALID cycle can never be accepted.
   assign sample_valid = (state_q == S_VALID) && enable_q;
   assign handshake    = sample_valid && sample_ready;

   // RAM port 2 is only clocked during the two address phases of a fetch.
   assign mem_chipselect = (state_q == S_ADDR_LO) || (state_q == S_CAP_LO);
   assign mem_clken      = mem_chipselect;
   assign mem_write      = 1'b0;
   assign mem_address    = (state_q == S_ADDR_LO) ? rd_ptr_q :
                           (state_q == S_CAP_LO)  ? rd_ptr_q + ADDR_W'(1) : '0;

   assign sample_data  = data_q;
   assign csr_readdata = readdata_q;
   assign irq          = irq_en_q && (low_water || underrun_q);

   assign unused_wdata = ^csr_writedata[31:ADDR_W];

   // Control and pointer next-state; flush wins over a same-cycle handshake.
   always_comb begin
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ctrl) begin
         enable_d = csr_writedata[0];
         irq_en_d = csr_writedata[1];
      end
      if (wr_wptr) begin
         wr_ptr_d = csr_writedata[ADDR_W-1:0];
      end
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else if (handshake) begin
         rd_ptr_d = rd_ptr_q + PAIR;
      end
   end

   // Level after this cycle's pointer updates decides back-to-back fetching.
   assign level_next    = wr_ptr_d - rd_ptr_d;
   assign has_pair_next = (level_next >= PAIR);

   // Fetch sequencer next-state and byte capture.
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (enable_q && has_pair) begin
               state_d = S_ADDR_LO;
            end
         end
         S_ADDR_LO: begin
            state_d = S_CAP_LO;
         end
         S_CAP_LO: begin
            lo_d    = mem_readdata;
            state_d = S_CAP_HI;
         end
         S_CAP_HI: begin
            data_d  = {mem_readdata, lo_q};
            state_d = S_VALID;
         end
         S_VALID: begin
            if (handshake) begin
               state_d = has_pair_next ? S_ADDR_LO : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Abort discards any partial sample and keeps the presented one.
      if (!enable_q || flush) begin
         state_d = S_IDLE;
         data_d  = data_q;
      end
   end

   // Underrun is an edge event so a held request only counts once.
   assign urun_cond = enable_q && sample_ready && !sample_valid && !has_pair;
   assign urun_set  = urun_cond && !urun_cond_q;

   // Sticky underrun flag; a new event beats a same-cycle clear.
   always_comb begin
      underrun_d = underrun_q;
      if (urun_set) begin
         underrun_d = 1'b1;
      end else if (urun_clr) begin
         underrun_d = 1'b0;
      end
   end

`ifdef AUDIO_UNDERRUN_CNT_EN
   logic [7:0] urun_cnt_q, urun_cnt_d;
   logic [7:0] urun_cnt_base;

   // Saturating event counter, cleared together with the sticky flag.
   always_comb begin
      urun_cnt_base = urun_clr ? 8'h00 : urun_cnt_q;
      urun_cnt_d    = urun_cnt_base;
      if (urun_set && (urun_cnt_base != 8'hFF)) begin
         urun_cnt_d = urun_cnt_base + 8'h01;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         urun_cnt_q <= 8'h00;
      end else begin
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign cnt_field = urun_cnt_q;
`else
   assign cnt_field = 8'h00;
`endif

   // CSR read mux, registered for one cycle of read latency.
   always_comb begin
      status                = '0;
      status[0]             = empty;
      status[1]             = underrun_q;
      status[2]             = low_water;
      status[4 +: ADDR_W]   = level;
      status[31:24]         = cnt_field;
      readdata_d            = readdata_q;
      if (csr_read) begin
         case (csr_address)
            A_CTRL:   readdata_d = 32'({irq_en_q, enable_q});
            A_WR_PTR: readdata_d = 32'(wr_ptr_q);
            A_RD_PTR: readdata_d = 32'(rd_ptr_q);
            A_STATUS: readdata_d = status;
            default:  readdata_d = '0;
         endcase
      end
   end

   // State, pointer, control and data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         enable_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         underrun_q  <= 1'b0;
         urun_cond_q <= 1'b0;
         lo_q        <= 8'h00;
         data_q      <= 16'h0000;
         readdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         enable_q    <= enable_d;
         irq_en_q    <= irq_en_d;
         underrun_q  <= underrun_d;
         urun_cond_q <= urun_cond;
         lo_q        <= lo_d;
         data_q      <= data_d;
         readdata_q  <= readdata_d;
      end
   end

endmodule
